// File: rtl/keypad_digit_sequencer.sv
// keypad_digit_sequencer
// Front-end for the six-digit lock: buffers keypad digits, then on ENTER
// replays them as three registered pairs (in_a/in_b/sel + wr_en strobe)
// followed by a judge request.
// Optional build macro: KEYPAD_TIMEOUT_EN (discard partial entries after
// TIMEOUT_CYCLES idle cycles). Without it, partial entries persist.
module keypad_digit_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_enter,
    input  logic       key_back,
    output logic [3:0] in_a,
    output logic [3:0] in_b,
    output logic [1:0] sel,
    output logic       wr_en,
    output logic       judge_req,
    output logic [2:0] digit_cnt,
    output logic       busy,
    output logic       err_key,
    output logic       timeout_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_HI  = 3'd1,
        ST_WR_MID = 3'd2,
        ST_WR_LO  = 3'd3,
        ST_JUDGE  = 3'd4
    } state_t;

    state_t     r_state, w_state;
    logic [3:0] r_slot [6];
    logic [3:0] w_slot [6];
    logic [2:0] r_cnt, w_cnt;
    logic [3:0] r_in_a, w_in_a, r_in_b, w_in_b;
    logic [1:0] r_sel, w_sel;
    logic       r_wr_en, w_wr_en, r_judge, w_judge;
    logic       r_busy, w_busy, r_err, w_err;
    logic       w_any_key;
    logic       w_timeout_hit;

    assign w_any_key = key_valid | key_enter | key_back;

`ifdef KEYPAD_TIMEOUT_EN
    logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt;
    logic             r_timeout;

    // A partial entry expires when the idle counter has reached its last count
    // and this cycle still carries no key strobe.
    assign w_timeout_hit = (r_state == ST_IDLE) && !w_any_key && (r_cnt != 3'd0) &&
                           (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Inactivity counter next value: runs only while a partial entry waits in IDLE.
    always_comb begin
        w_idle_cnt = r_idle_cnt;
        if ((r_state != ST_IDLE) || (r_cnt == 3'd0) || w_any_key || w_timeout_hit) begin
            w_idle_cnt = {CNT_W{1'b0}};
        end else begin
            w_idle_cnt = r_idle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Inactivity counter and registered timeout pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_idle_cnt <= {CNT_W{1'b0}};
            r_timeout  <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_cnt;
            r_timeout  <= w_timeout_hit;
        end
    end

    assign timeout_pulse = r_timeout;
`else
    // No timeout hardware; the parameters are still referenced so both builds
    // share one parameter interface.
    assign w_timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0) & (CNT_W > 0);
    assign timeout_pulse = 1'b0;
`endif

    // Next-state, buffer and output-register values; defaults hold state and
    // keep strobes low.
    always_comb begin
        w_state = r_state;
        for (int i = 0; i < 6; i++) begin
            w_slot[i] = r_slot[i];
        end
        w_cnt   = r_cnt;
        w_in_a  = r_in_a;
        w_in_b  = r_in_b;
        w_sel   = r_sel;
        w_wr_en = 1'b0;
        w_judge = 1'b0;
        w_busy  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_back) begin
                    if (r_cnt != 3'd0) begin
                        for (int i = 0; i < 6; i++) begin
                            if (3'(i) == (r_cnt - 3'd1)) begin
                                w_slot[i] = 4'd0;
                            end else begin
                                w_slot[i] = r_slot[i];
                            end
                        end
                        w_cnt = r_cnt - 3'd1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (key_enter) begin
                    if (r_cnt == 3'd6) begin
                        w_state = ST_WR_HI;
                        w_sel   = 2'b00;
                        w_in_a  = r_slot[0];
                        w_in_b  = r_slot[1];
                        w_wr_en = 1'b1;
                        w_busy  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (key_valid) begin
                    if ((key_code > 4'd9) || (r_cnt == 3'd6)) begin
                        w_err = 1'b1;
                    end else begin
                        for (int i = 0; i < 6; i++) begin
                            if (3'(i) == r_cnt) begin
                                w_slot[i] = key_code;
                            end else begin
                                w_slot[i] = r_slot[i];
                            end
                        end
                        w_cnt = r_cnt + 3'd1;
                    end
                end else if (w_timeout_hit) begin
                    for (int i = 0; i < 6; i++) begin
                        w_slot[i] = 4'd0;
                    end
                    w_cnt = 3'd0;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_WR_HI: begin
                w_state = ST_WR_MID;
                w_sel   = 2'b01;
                w_in_a  = r_slot[2];
                w_in_b  = r_slot[3];
                w_wr_en = 1'b1;
                w_busy  = 1'b1;
            end
            ST_WR_MID: begin
                w_state = ST_WR_LO;
                w_sel   = 2'b10;
                w_in_a  = r_slot[4];
                w_in_b  = r_slot[5];
                w_wr_en = 1'b1;
                w_busy  = 1'b1;
            end
            ST_WR_LO: begin
                w_state = ST_JUDGE;
                w_sel   = 2'b11;
                w_judge = 1'b1;
                w_busy  = 1'b1;
            end
            ST_JUDGE: begin
                w_state = ST_IDLE;
                for (int i = 0; i < 6; i++) begin
                    w_slot[i] = 4'd0;
                end
                w_cnt = 3'd0;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, digit buffer and all registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            for (int i = 0; i < 6; i++) begin
                r_slot[i] <= 4'd0;
            end
            r_cnt   <= 3'd0;
            r_in_a  <= 4'd0;
            r_in_b  <= 4'd0;
            r_sel   <= 2'b00;
            r_wr_en <= 1'b0;
            r_judge <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            for (int i = 0; i < 6; i++) begin
                r_slot[i] <= w_slot[i];
            end
            r_cnt   <= w_cnt;
            r_in_a  <= w_in_a;
            r_in_b  <= w_in_b;
            r_sel   <= w_sel;
            r_wr_en <= w_wr_en;
            r_judge <= w_judge;
            r_busy  <= w_busy;
            r_err   <= w_err;
        end
    end

    assign in_a      = r_in_a;
    assign in_b      = r_in_b;
    assign sel       = r_sel;
    assign wr_en     = r_wr_en;
    assign judge_req = r_judge;
    assign digit_cnt = r_cnt;
    assign busy      = r_busy;
    assign err_key   = r_err;

endmodule

// File: tb/tb_keypad_digit_sequencer.sv
// Testbench for keypad_digit_sequencer: directed and random key streams
// checked every cycle against a queue-based model of the keypad entry.
module tb_keypad_digit_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_back = 1'b0;
    logic [3:0] in_a, in_b;
    logic [1:0] sel;
    logic       wr_en, judge_req, busy, err_key, timeout_pulse;
    logic [2:0] digit_cnt;

    keypad_digit_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
        .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
        .key_enter(key_enter), .key_back(key_back), .in_a(in_a), .in_b(in_b),
        .sel(sel), .wr_en(wr_en), .judge_req(judge_req), .digit_cnt(digit_cnt),
        .busy(busy), .err_key(err_key), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // One expected output cycle of a replay trace.
    typedef struct packed {
        logic       wr;
        logic       judge;
        logic       bsy;
        logic       clr_buf;
        logic [1:0] s;
        logic [3:0] a;
        logic [3:0] b;
    } ent_t;

    int   q[$];
    ent_t sched[$];
    logic [3:0] m_a, m_b;
    logic [1:0] m_sel;
    logic m_wr, m_judge, m_busy, m_err, m_to;
    int   m_idle;
    int   errors = 0;
    int   checks = 0;

    function automatic ent_t mk(input logic wr, input logic jd, input logic bs,
                                input logic cb, input logic [1:0] s,
                                input int a, input int b);
        ent_t e;
        e.wr = wr; e.judge = jd; e.bsy = bs; e.clr_buf = cb;
        e.s = s; e.a = 4'(a); e.b = 4'(b);
        return e;
    endfunction

    task automatic model_reset();
        q.delete(); sched.delete();
        m_a = 4'd0; m_b = 4'd0; m_sel = 2'b00;
        m_wr = 1'b0; m_judge = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_to = 1'b0;
        m_idle = 0;
    endtask

    task automatic apply(input ent_t e);
        m_wr = e.wr; m_judge = e.judge; m_busy = e.bsy;
        if (e.clr_buf) begin
            q.delete();
        end else begin
            m_sel = e.s; m_a = e.a; m_b = e.b;
        end
    endtask

    // Reference behaviour for one rising edge with the given strobes.
    task automatic model_step(input logic v, input logic e, input logic bk, input logic [3:0] code);
        m_err = 1'b0; m_to = 1'b0; m_wr = 1'b0; m_judge = 1'b0;
        if (sched.size() > 0) begin
            apply(sched.pop_front());
            m_idle = 0;
        end else begin
            m_busy = 1'b0;
            if (bk) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_err = 1'b1;
            end else if (e) begin
                if (q.size() == 6) begin
                    apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, q[0], q[1]));
                    sched.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, q[2], q[3]));
                    sched.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, q[4], q[5]));
                    sched.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, q[4], q[5]));
                    sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 0, 0));
                end else begin
                    m_err = 1'b1;
                end
            end else if (v) begin
                if (code > 4'd9 || q.size() == 6) m_err = 1'b1;
                else q.push_back(int'(code));
            end
`ifdef KEYPAD_TIMEOUT_EN
            if (v || e || bk) m_idle = 0;
            else if (q.size() > 0) begin
                if (m_idle == TO - 1) begin
                    q.delete(); m_to = 1'b1; m_idle = 0;
                end else begin
                    m_idle++;
                end
            end else m_idle = 0;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".in_a"}, {4'd0, in_a}, {4'd0, m_a});
        chk({ctx, ".in_b"}, {4'd0, in_b}, {4'd0, m_b});
        chk({ctx, ".sel"}, {6'd0, sel}, {6'd0, m_sel});
        chk({ctx, ".wr_en"}, {7'd0, wr_en}, {7'd0, m_wr});
        chk({ctx, ".judge_req"}, {7'd0, judge_req}, {7'd0, m_judge});
        chk({ctx, ".digit_cnt"}, {5'd0, digit_cnt}, 8'(q.size()));
        chk({ctx, ".busy"}, {7'd0, busy}, {7'd0, m_busy});
        chk({ctx, ".err_key"}, {7'd0, err_key}, {7'd0, m_err});
        chk({ctx, ".timeout_pulse"}, {7'd0, timeout_pulse}, {7'd0, m_to});
    endtask

    task automatic cyc(input string ctx, input logic v, input logic e, input logic bk, input logic [3:0] code);
        key_valid = v; key_enter = e; key_back = bk; key_code = code;
        @(posedge clk);
        model_step(v, e, bk, code);
        #1;
        check_all(ctx);
        key_valid = 1'b0; key_enter = 1'b0; key_back = 1'b0; key_code = 4'd0;
    endtask

    task automatic key(input string ctx, input int d);
        cyc(ctx, 1'b1, 1'b0, 1'b0, 4'(d));
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) cyc(ctx, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        int r;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        clr = 1'b1;

        // Full entry and replay.
        for (int d = 1; d <= 6; d++) key("seq123456", d);
        cyc("enter1", 1'b0, 1'b1, 1'b0, 4'd0);
        idle("replay1", 6);

        // Early ENTER rejected, then completed.
        key("k78", 7); key("k78", 8);
        cyc("early_enter", 1'b0, 1'b1, 1'b0, 4'd0);
        idle("early_enter_after", 2);
        key("k9012", 9); key("k9012", 0); key("k9012", 1); key("k9012", 2);
        cyc("enter2", 1'b0, 1'b1, 1'b0, 4'd0);
        idle("replay2", 6);

        // Back-space editing, and back with empty buffer.
        key("kb", 1); key("kb", 2); key("kb", 3);
        cyc("back", 1'b0, 1'b0, 1'b1, 4'd0);
        key("kb", 4); key("kb", 5); key("kb", 6); key("kb", 7);
        cyc("enter3", 1'b0, 1'b1, 1'b0, 4'd0);
        idle("replay3", 6);
        cyc("back_empty", 1'b0, 1'b0, 1'b1, 4'd0);
        idle("back_empty_after", 1);

        // Illegal code, seventh digit, strobes while busy.
        key("code12", 12);
        idle("code12_after", 1);
        for (int d = 0; d < 6; d++) key("fill", 3 + d);
        key("seventh", 9);
        cyc("enter4", 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++)
            cyc("busy_keys", 1'b1, 1'(i & 1), 1'(i >> 1), 4'(i + 1));
        idle("replay4", 2);

        // Coincident back + digit.
        key("co", 1); key("co", 2); key("co", 3);
        cyc("back_plus_5", 1'b1, 1'b0, 1'b1, 4'd5);
        cyc("back_plus_5_b", 1'b0, 1'b0, 1'b1, 4'd0);
        cyc("back_plus_5_c", 1'b0, 1'b0, 1'b1, 4'd0);

        // Reset during WR_MID aborts the replay.
        for (int d = 0; d < 6; d++) key("pre_rst", d);
        cyc("enter5", 1'b0, 1'b1, 1'b0, 4'd0);
        cyc("wr_mid", 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        clr = 1'b1;
        idle("post_reset", 6);

        // Partial entry left idle.
        key("partial", 4); key("partial", 5); key("partial", 6);
        idle("partial_idle", TO + 4);
        cyc("partial_clear", 1'b0, 1'b0, 1'b1, 4'd0);
        cyc("partial_clear", 1'b0, 1'b0, 1'b1, 4'd0);
        cyc("partial_clear", 1'b0, 1'b0, 1'b1, 4'd0);
        idle("partial_clear", 2);

        // Randomised key stream.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       cyc("rnd", 1'b1, 1'b0, 1'b0, 4'($urandom_range(10, 15)));
            else if (r < 55) cyc("rnd", 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 9)));
            else if (r < 63) cyc("rnd", 1'b0, 1'b0, 1'b1, 4'd0);
            else if (r < 75) cyc("rnd", 1'b0, 1'b1, 1'b0, 4'd0);
            else if (r < 82) cyc("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else             cyc("rnd", 1'b0, 1'b0, 1'b0, 4'd0);
        end
        idle("drain", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
